sub_bytes_arbiter: RTL and testbench
====================================

SUB_BYTES_ARBITER -- requirements
Module: sub_bytes_arbiter

Interface
REQ-001 Parameter WAIT_LIMIT, default 64: maximum engine-response cycles before the arbiter declares a timeout.
REQ-002 Port clk_in, input, 1: the single clock.
REQ-003 Port rst_n_in, input, 1: reset, asynchronous and active-low.
REQ-004 Port req_in, input, [1:0]: service requests; bit 0 is the cipher round path, bit 1 is key expansion.
REQ-005 Port blk0_in, input, [15:0][7:0]: block from requester 0.
REQ-006 Port blk1_in, input, [15:0][7:0]: block from requester 1.
REQ-007 Port grant_out, output, [1:0]: one-hot; identifies the requester currently being served.
REQ-008 Port done_out, output, [1:0]: one-cycle pulse to the served requester.
REQ-009 Port result_out, output, [15:0][7:0]: substituted block; valid while done_out is nonzero.
REQ-010 Port timeout_out, output, 1: one-cycle pulse, coincident with done_out, when the engine failed to respond.
REQ-011 Port busy_out, output, 1: high in any state other than IDLE.
REQ-012 Port eng_start_out, output, 1: one-cycle start pulse to the sub_bytes engine (its new_block_in).
REQ-013 Port eng_block_out, output, [15:0][7:0]: latched block presented to the engine; held stable from start through completion.
REQ-014 Port eng_block_in, input, [15:0][7:0]: engine result.
REQ-015 Port eng_valid_in, input, 1: engine result valid (the engine's valid_out).

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, DONE; all outputs are registered.
REQ-017 IDLE, no req_in bit set: the FSM SHALL remain in IDLE.
REQ-018 IDLE, any req_in bit set, at edge t, the arbiter SHALL:
- select the winner;
- latch the winner's block into eng_block_out;
- set grant_out;
- drive eng_start_out high for cycle t..t+1 only;
- clear the wait counter;
- move to WAIT.
REQ-019 WAIT SHALL increment the wait counter every cycle; eng_valid_in is sampled from the cycle after the start pulse.
REQ-020 WAIT, eng_valid_in high: the arbiter SHALL load result_out from eng_block_in, pulse done_out at the grant_out bit, and move to DONE.
REQ-021 WAIT, counter reaches WAIT_LIMIT with no eng_valid_in: the arbiter SHALL set result_out to 0, pulse done_out and timeout_out together, and move to DONE.
REQ-022 If eng_valid_in arrives in the same cycle the limit is reached, valid SHALL win and no timeout is raised.
REQ-023 DONE SHALL clear done_out, timeout_out and grant_out, then move to IDLE; the next arbitration occurs no earlier than one cycle after DONE.
REQ-024 eng_valid_in outside WAIT SHALL be ignored, with no output change.
REQ-025 Deassertion of req_in during WAIT SHALL NOT abort the transaction; done_out still pulses.
REQ-026 A requester SHALL hold req_in high until done_out and deassert it on the following edge; req_in still high in IDLE is treated as a new request.
REQ-027 Changes on blk0_in or blk1_in after the grant SHALL NOT affect eng_block_out.
REQ-028 The wait counter width SHALL be $clog2(WAIT_LIMIT+1) and the counter SHALL saturate, never wrap.

Reset
REQ-029 Assertion of rst_n_in SHALL immediately, without clock, force:
- state to IDLE;
- grant_out, done_out, timeout_out, busy_out and eng_start_out to 0;
- result_out and eng_block_out to 0;
- the wait counter to 0;
- the round-robin pointer to requester 1, so requester 0 wins the first contention.
REQ-030 Reset mid-transaction SHALL discard the transaction with no done_out pulse; a late eng_valid_in after reset SHALL be ignored per REQ-024.
REQ-031 Reset deassertion SHALL take effect on the next clk_in edge; the first arbitration is possible at that edge.

Configuration
REQ-032 The macro SUB_BYTES_ARB_ROUND_ROBIN_EN selects the contention policy.
- Defined: on contention the requester not granted last wins; the pointer updates only on grant.
- Undefined: fixed priority, requester 0 always wins, and no pointer register is built.

Verification
REQ-033 Single request: req_in=2'b01, blk0_in all 0x00, engine model returns after 35 cycles -> eng_start_out pulses once, done_out=2'b01 at cycle 36, result_out all 0x63, timeout_out=0.
REQ-034 Contention with ROUND_ROBIN_EN defined: req_in=2'b11 held through three services -> grant order 0,1,0. Same stimulus with the macro undefined -> grant order 0,0,0.
REQ-035 Timeout: WAIT_LIMIT=8, engine model never responds -> done_out and timeout_out pulse 8 cycles after the start, result_out=0, busy_out low two cycles later.
REQ-036 Input stability: blk1_in=0x53 in every byte, granted, then changed to 0xFF during WAIT -> result_out all 0xED.
REQ-037 Mid-operation reset: rst_n_in low for 3 cycles during WAIT, engine valid arriving afterwards -> no done_out pulse, all outputs 0, next request served normally.
REQ-038 Stray valid: eng_valid_in pulsed while in IDLE -> result_out and done_out unchanged.

Source files
------------

// File: rtl/sub_bytes_arbiter_if.sv
// sub_bytes_arbiter_if: request, result and engine-side signals of the
// sub_bytes arbiter. The slave modport is the arbiter's view; the master
// modport is the view of whatever drives the requesters and the engine.
interface sub_bytes_arbiter_if;
    logic [1:0]       req_in;
    logic [15:0][7:0] blk0_in;
    logic [15:0][7:0] blk1_in;
    logic [1:0]       grant_out;
    logic [1:0]       done_out;
    logic [15:0][7:0] result_out;
    logic             timeout_out;
    logic             busy_out;
    logic             eng_start_out;
    logic [15:0][7:0] eng_block_out;
    logic [15:0][7:0] eng_block_in;
    logic             eng_valid_in;

    modport slave (
        input  req_in, blk0_in, blk1_in, eng_block_in, eng_valid_in,
        output grant_out, done_out, result_out, timeout_out, busy_out,
               eng_start_out, eng_block_out
    );

    modport master (
        output req_in, blk0_in, blk1_in, eng_block_in, eng_valid_in,
        input  grant_out, done_out, result_out, timeout_out, busy_out,
               eng_start_out, eng_block_out
    );
endinterface

// File: rtl/sub_bytes_arbiter.sv
// sub_bytes_arbiter: shares one sub_bytes engine between the cipher round
// path (requester 0) and key expansion (requester 1). The winner's block is
// latched, the engine is started with a one-cycle pulse, and the result (or
// a zero block on timeout) is returned with a one-cycle done pulse.
//
// Optional feature: define SUB_BYTES_ARB_ROUND_ROBIN_EN for round-robin
// contention handling; otherwise requester 0 has fixed priority.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; arbitrate any pending request
// WAIT  | engine started; wait for eng_valid_in or the wait limit
// DONE  | done pulse issued; drop grant and return to IDLE
module sub_bytes_arbiter #(
    parameter int WAIT_LIMIT = 64
) (
    input logic               clk_in,
    input logic               rst_n_in,
    sub_bytes_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;
    logic [1:0]       grant_q;
    logic [1:0]       done_q;
    logic [127:0]     result_q;
    logic             timeout_q;
    logic             busy_q;
    logic             start_q;
    logic [127:0]     eng_block_q;

    logic             win_idx;
    logic [1:0]       win_onehot;
    logic [127:0]     win_blk;

`ifdef SUB_BYTES_ARB_ROUND_ROBIN_EN
    logic last_idx;

    // On contention, the requester that was not served last wins
    always_comb begin
        win_idx = 1'b0;
        case (bus.req_in)
            2'b10:   win_idx = 1'b1;
            2'b11:   win_idx = ~last_idx;
            default: win_idx = 1'b0;
        endcase
    end

    // Pointer holds the last winner and moves only when a grant is issued
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_idx <= 1'b1;
        end else if (state == ST_IDLE && bus.req_in != 2'b00) begin
            last_idx <= win_idx;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is requesting
    always_comb begin
        win_idx = ~bus.req_in[0];
    end
`endif

    // Winner's one-hot grant, its block, and the saturating counter step
    always_comb begin
        win_onehot   = win_idx ? 2'b10 : 2'b01;
        win_blk      = win_idx ? bus.blk1_in : bus.blk0_in;
        wait_cnt_nxt = (wait_cnt == LIMIT) ? LIMIT : wait_cnt + CNT_W'(1);
    end

    // Arbitration FSM; every output is a register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            grant_q     <= 2'b00;
            done_q      <= 2'b00;
            result_q    <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            eng_block_q <= '0;
        end else begin
            start_q   <= 1'b0;
            done_q    <= 2'b00;
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_in != 2'b00) begin
                        grant_q     <= win_onehot;
                        eng_block_q <= win_blk;
                        start_q     <= 1'b1;
                        wait_cnt    <= '0;
                        busy_q      <= 1'b1;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt_nxt;
                    // valid during the start-pulse cycle cannot belong to this block
                    if (bus.eng_valid_in && !start_q) begin
                        result_q <= bus.eng_block_in;
                        done_q   <= grant_q;
                        state    <= ST_DONE;
                    end else if (wait_cnt_nxt == LIMIT) begin
                        result_q  <= '0;
                        done_q    <= grant_q;
                        timeout_q <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    grant_q <= 2'b00;
                    busy_q  <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant_out     = grant_q;
    assign bus.done_out      = done_q;
    assign bus.result_out    = result_q;
    assign bus.timeout_out   = timeout_q;
    assign bus.busy_out      = busy_q;
    assign bus.eng_start_out = start_q;
    assign bus.eng_block_out = eng_block_q;

endmodule

// File: tb/tb_sub_bytes_arbiter.sv
// tb_sub_bytes_arbiter: randomized and directed stimulus for the sub_bytes
// arbiter. A transaction-level model (elapsed cycles since start, queue-free
// arithmetic) predicts every output each cycle; directed cases pin exact
// latencies and values. A second instance with WAIT_LIMIT=8 covers the short
// timeout case. Define SUB_BYTES_ARB_ROUND_ROBIN_EN for the round-robin build.
module tb_sub_bytes_arbiter;
    localparam int WL   = 64;
    localparam int WL_T = 8;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [7:0] sbox_t [256];

    sub_bytes_arbiter_if u_if ();
    sub_bytes_arbiter_if t_if ();

    sub_bytes_arbiter #(.WAIT_LIMIT(WL)) u_dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (u_if.slave)
    );

    sub_bytes_arbiter #(.WAIT_LIMIT(WL_T)) t_dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (t_if.slave)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int i = 1; i < 256; i++)
            if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_block(input logic [127:0] b);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox_t[b[i*8 +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- engine model (sole driver of u_if engine inputs) -----
    int           eng_lat_sel = 1;  // >0 fixed latency, 0 random, -1 never
    int           eng_cnt     = 0;
    int           stray_req   = 0;
    int           stray_ack   = 0;
    logic [127:0] eng_pend    = '0;

    initial begin : engine
        int lat;
        int r;
        u_if.eng_valid_in = 1'b0;
        u_if.eng_block_in = '0;
        forever begin
            @(negedge clk_in);
            u_if.eng_valid_in = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    u_if.eng_valid_in = 1'b1;
                    u_if.eng_block_in = eng_pend;
                end
            end else if (stray_ack != stray_req) begin
                stray_ack++;
                u_if.eng_valid_in = 1'b1;
                u_if.eng_block_in = rand128();
            end
            if (u_if.eng_start_out) begin
                if (eng_lat_sel != 0) lat = eng_lat_sel;
                else begin
                    r = $urandom_range(0, 15);
                    lat = (r == 0) ? -1 : (r == 1) ? 63 : (r == 2) ? 64 : $urandom_range(1, 12);
                end
                if (lat > 0) begin
                    eng_pend = sub_block(u_if.eng_block_out);
                    eng_cnt  = lat;
                end
            end
        end
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [1:0]   e_grant = 2'b00, e_done = 2'b00;
    logic [127:0] e_res = '0, e_blk = '0;
    logic         e_to = 1'b0, e_busy = 1'b0, e_start = 1'b0;
    int           m_last = 1;

    function automatic int pick(input logic [1:0] r);
`ifdef SUB_BYTES_ARB_ROUND_ROBIN_EN
        if (r == 2'b11) return 1 - m_last;
`endif
        return r[0] ? 0 : 1;
    endfunction

    initial begin : model
        int ph;   // 0 idle, 1 engine running, 2 finishing
        int el;   // edges since the start edge
        int w;
        ph = 0; el = 0;
        forever begin
            @(posedge clk_in);
            if (!rst_n_in) begin
                ph = 0; m_last = 1;
                e_grant = 2'b00; e_done = 2'b00; e_res = '0; e_blk = '0;
                e_to = 1'b0; e_busy = 1'b0; e_start = 1'b0;
            end else begin
                e_done = 2'b00; e_to = 1'b0; e_start = 1'b0;
                if (ph == 1) begin
                    el++;
                    if (el >= 2 && u_if.eng_valid_in) begin
                        e_res = u_if.eng_block_in; e_done = e_grant; ph = 2;
                    end else if (el >= WL) begin
                        e_res = '0; e_done = e_grant; e_to = 1'b1; ph = 2;
                    end
                end else if (ph == 2) begin
                    e_grant = 2'b00; e_busy = 1'b0; ph = 0;
                end else if (u_if.req_in != 2'b00) begin
                    w = pick(u_if.req_in);
                    m_last  = w;
                    e_grant = (w == 1) ? 2'b10 : 2'b01;
                    e_blk   = (w == 1) ? u_if.blk1_in : u_if.blk0_in;
                    e_start = 1'b1; e_busy = 1'b1; el = 0; ph = 1;
                end
            end
            #1;
            chk("grant",     u_if.grant_out,     e_grant);
            chk("done",      u_if.done_out,      e_done);
            chk("result",    u_if.result_out,    e_res);
            chk("timeout",   u_if.timeout_out,   e_to);
            chk("busy",      u_if.busy_out,      e_busy);
            chk("eng_start", u_if.eng_start_out, e_start);
            chk("eng_block", u_if.eng_block_out, e_blk);
        end
    end

    // ---------------- directed helpers --------------------------------------
    task automatic wait_sig(input string name, input int which, input int bound, output int at);
        logic hit;
        at = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk_in);
            case (which)
                0:       hit = u_if.eng_start_out;
                1:       hit = (u_if.done_out != 2'b00);
                2:       hit = t_if.eng_start_out;
                default: hit = (t_if.done_out != 2'b00);
            endcase
            if (hit) begin
                at = cyc;
                return;
            end
        end
        total++; bad++;
        $display("FAIL %s: no event within %0d cycles", name, bound);
    endtask

    task automatic run_random(input int ncyc);
        logic [1:0] rq;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk_in);
            rq = u_if.req_in;
            for (int i = 0; i < 2; i++) begin
                if (rq[i] && u_if.done_out[i]) rq[i] = 1'b0;
                else if (!rq[i] && $urandom_range(0, 7) == 0) rq[i] = 1'b1;
            end
            u_if.req_in  = rq;
            u_if.blk0_in = rand128();
            u_if.blk1_in = rand128();
        end
        for (int n = 0; n < 300; n++) begin
            @(negedge clk_in);
            rq = u_if.req_in;
            for (int i = 0; i < 2; i++)
                if (rq[i] && u_if.done_out[i]) rq[i] = 1'b0;
            u_if.req_in = rq;
            if (rq == 2'b00 && !u_if.busy_out && eng_cnt == 0) break;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence -----------------------------------------
    initial begin : main
        int s, e, seen;
        logic [1:0]   g [3];
        logic [127:0] b;

        u_if.req_in = 2'b00; u_if.blk0_in = '0; u_if.blk1_in = '0;
        t_if.req_in = 2'b00; t_if.blk0_in = '0; t_if.blk1_in = '0;
        t_if.eng_valid_in = 1'b0; t_if.eng_block_in = '0;
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        chk("model_sbox_00", sbox_t[8'h00], 8'h63);
        chk("model_sbox_53", sbox_t[8'h53], 8'hed);

        repeat (3) @(negedge clk_in);
        chk("rst_grant",  u_if.grant_out, 2'b00);
        chk("rst_busy",   u_if.busy_out, 1'b0);
        chk("rst_result", u_if.result_out, 128'h0);
        chk("rst_eblk",   u_if.eng_block_out, 128'h0);
        chk("rst_t_start", t_if.eng_start_out, 1'b0);
        rst_n_in = 1'b1;

        // short timeout on the WAIT_LIMIT=8 instance; its engine never answers
        t_if.blk0_in = rand128();
        t_if.req_in  = 2'b01;
        wait_sig("t_start", 2, 5, s);
        wait_sig("t_done", 3, 20, e);
        chk("t_latency", e - s, 8);
        chk("t_done_val", t_if.done_out, 2'b01);
        chk("t_timeout", t_if.timeout_out, 1'b1);
        chk("t_result", t_if.result_out, 128'h0);
        chk("t_busy_in_done", t_if.busy_out, 1'b1);
        t_if.req_in = 2'b00;
        repeat (2) @(negedge clk_in);
        chk("t_busy_after", t_if.busy_out, 1'b0);
        chk("t_timeout_clr", t_if.timeout_out, 1'b0);

        // single request, engine answers 35 cycles after taking the start
        eng_lat_sel = 35;
        u_if.blk0_in = '0;
        u_if.req_in  = 2'b01;
        wait_sig("single_start", 0, 5, s);
        @(negedge clk_in);
        chk("single_start_once", u_if.eng_start_out, 1'b0);
        wait_sig("single_done", 1, 60, e);
        chk("single_latency", e - s, 36);
        chk("single_done_val", u_if.done_out, 2'b01);
        chk("single_result", u_if.result_out, {16{8'h63}});
        chk("single_timeout", u_if.timeout_out, 1'b0);
        u_if.req_in = 2'b00;
        repeat (2) @(negedge clk_in);

        // block changes after the grant must not reach the engine
        eng_lat_sel = 10;
        u_if.blk1_in = {16{8'h53}};
        u_if.req_in  = 2'b10;
        wait_sig("stab_start", 0, 5, s);
        u_if.blk1_in = {16{8'hff}};
        wait_sig("stab_done", 1, 30, e);
        chk("stab_result", u_if.result_out, {16{8'hed}});
        chk("stab_eblk", u_if.eng_block_out, {16{8'h53}});
        chk("stab_done_val", u_if.done_out, 2'b10);
        u_if.req_in = 2'b00;
        repeat (2) @(negedge clk_in);

        // stray engine valid while idle
        stray_req++;
        for (int k = 0; k < 10 && stray_ack != stray_req; k++) @(negedge clk_in);
        repeat (2) @(negedge clk_in);
        chk("stray_result", u_if.result_out, {16{8'hed}});
        chk("stray_done", u_if.done_out, 2'b00);
        chk("stray_busy", u_if.busy_out, 1'b0);

        // contention held through three services
        eng_lat_sel = 4;
        u_if.req_in = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_sig("cont_start", 0, 20, s);
            g[k] = u_if.grant_out;
            wait_sig("cont_done", 1, 20, e);
        end
        u_if.req_in = 2'b00;
`ifdef SUB_BYTES_ARB_ROUND_ROBIN_EN
        chk("cont_g0", g[0], 2'b01);
        chk("cont_g1", g[1], 2'b10);
        chk("cont_g2", g[2], 2'b01);
`else
        chk("cont_g0", g[0], 2'b01);
        chk("cont_g1", g[1], 2'b01);
        chk("cont_g2", g[2], 2'b01);
`endif
        repeat (2) @(negedge clk_in);

        // reset during WAIT, engine answers after reset is released
        eng_lat_sel = 20;
        u_if.blk0_in = rand128();
        u_if.req_in  = 2'b01;
        wait_sig("mrst_start", 0, 5, s);
        repeat (5) @(negedge clk_in);
        rst_n_in = 1'b0;
        u_if.req_in = 2'b00;
        #1;
        chk("mrst_grant", u_if.grant_out, 2'b00);
        chk("mrst_busy", u_if.busy_out, 1'b0);
        chk("mrst_eblk", u_if.eng_block_out, 128'h0);
        chk("mrst_result", u_if.result_out, 128'h0);
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_in);
            if (u_if.done_out != 2'b00) seen++;
        end
        chk("mrst_no_done", seen, 0);
        chk("mrst_late_valid_consumed", eng_cnt, 0);
        eng_lat_sel = 3;
        b = rand128();
        u_if.blk0_in = b;
        u_if.req_in  = 2'b01;
        wait_sig("mrst_next_done", 1, 20, e);
        chk("mrst_next_result", u_if.result_out, sub_block(b));
        u_if.req_in = 2'b00;
        repeat (2) @(negedge clk_in);

        // full-length timeout on the main instance
        eng_lat_sel = -1;
        u_if.req_in = 2'b10;
        wait_sig("to_start", 0, 5, s);
        wait_sig("to_done", 1, 80, e);
        chk("to_latency", e - s, WL);
        chk("to_flag", u_if.timeout_out, 1'b1);
        chk("to_result", u_if.result_out, 128'h0);
        u_if.req_in = 2'b00;
        repeat (2) @(negedge clk_in);

        // valid arriving on the limit cycle wins over timeout
        eng_lat_sel = WL - 1;
        b = rand128();
        u_if.blk0_in = b;
        u_if.req_in  = 2'b01;
        wait_sig("edge_start", 0, 5, s);
        wait_sig("edge_done", 1, 80, e);
        chk("edge_latency", e - s, WL);
        chk("edge_no_timeout", u_if.timeout_out, 1'b0);
        chk("edge_result", u_if.result_out, sub_block(b));
        u_if.req_in = 2'b00;
        repeat (2) @(negedge clk_in);

        eng_lat_sel = 0;
        run_random(2500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
